// File: rtl/clock_pkg.sv
// Shared definitions for the set-time entry controller: state encoding,
// per-digit maxima and digit select codes.
package clock_pkg;

    localparam logic [2:0] ST_IDLE_C    = 3'd0;
    localparam logic [2:0] ST_EDIT_HL_C = 3'd1;
    localparam logic [2:0] ST_EDIT_HR_C = 3'd2;
    localparam logic [2:0] ST_EDIT_ML_C = 3'd3;
    localparam logic [2:0] ST_EDIT_MR_C = 3'd4;
    localparam logic [2:0] ST_DONE_C    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_C,
        ST_EDIT_HL = ST_EDIT_HL_C,
        ST_EDIT_HR = ST_EDIT_HR_C,
        ST_EDIT_ML = ST_EDIT_ML_C,
        ST_EDIT_MR = ST_EDIT_MR_C,
        ST_DONE    = ST_DONE_C
    } state_t;

    localparam logic [1:0] HL_MAX    = 2'd2;
    localparam logic [3:0] HR_MAX    = 4'd9;
    localparam logic [3:0] HR_MAX_H2 = 4'd3;
    localparam logic [2:0] ML_MAX    = 3'd5;
    localparam logic [3:0] MR_MAX    = 4'd9;

    localparam logic [1:0] DIGIT_HL = 2'd0;
    localparam logic [1:0] DIGIT_HR = 2'd1;
    localparam logic [1:0] DIGIT_ML = 2'd2;
    localparam logic [1:0] DIGIT_MR = 2'd3;

    function automatic logic is_edit(input state_t s);
        return (s == ST_EDIT_HL) || (s == ST_EDIT_HR) ||
               (s == ST_EDIT_ML) || (s == ST_EDIT_MR);
    endfunction

    function automatic logic [1:0] sel_of_state(input state_t s);
        case (s)
            ST_EDIT_HR: return DIGIT_HR;
            ST_EDIT_ML: return DIGIT_ML;
            ST_EDIT_MR: return DIGIT_MR;
            default:    return DIGIT_HL;
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit register with parallel load and increment that wraps to 0
// once the value has reached max.
module bcd_digit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] max,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= (value >= max) ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/set_time_ctrl.sv
// Set-time digit entry: preloads current time, edits HL/HR/ML/MR with inc/next.
// Optional inactivity abort is enabled with SET_TIME_TIMEOUT_EN.
//
//   state      | meaning
//   ST_IDLE    | not in set-time mode; digits hold last value
//   ST_EDIT_HL | editing hours tens (0..2)
//   ST_EDIT_HR | editing hours units (0..9, 0..3 when HL=2)
//   ST_EDIT_ML | editing minutes tens (0..5)
//   ST_EDIT_MR | editing minutes units (0..9)
//   ST_DONE    | entry complete; ack held until set_time_en drops
module set_time_ctrl
    import clock_pkg::*;
#(
    parameter int BLINK_DIV    = 16,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_time_en,
    input  logic       inc_button,
    input  logic       next_button,
    input  logic [4:0] normal_hours,
    input  logic [5:0] normal_minutes,
    output logic [1:0] set_time_hours_left,
    output logic [3:0] set_time_hours_right,
    output logic [2:0] set_time_minutes_left,
    output logic [3:0] set_time_minutes_right,
    output logic       set_time_ack_flag,
    output logic       set_time_active,
    output logic [1:0] digit_sel,
    output logic       digit_blink
);

    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    state_t state, state_nxt;
    logic   in_edit, nxt_edit, btn, inc_act, load_all, to_hit;
    logic   inc_hl, inc_hr, inc_ml, inc_mr, clamp_hr;
    logic [1:0] h_tens;
    logic [3:0] h_ones, m_ones, hr_max, hr_load_val;
    logic [2:0] m_tens;
    logic [BW-1:0] blink_cnt;

    assign in_edit  = is_edit(state);
    assign nxt_edit = is_edit(state_nxt);
    assign btn      = inc_button | next_button;
    assign load_all = (state == ST_IDLE) && set_time_en;
    assign inc_act  = in_edit && set_time_en && inc_button && !next_button;
    assign inc_hl   = inc_act && (state == ST_EDIT_HL);
    assign inc_hr   = inc_act && (state == ST_EDIT_HR);
    assign inc_ml   = inc_act && (state == ST_EDIT_ML);
    assign inc_mr   = inc_act && (state == ST_EDIT_MR);

    // Binary-to-BCD split of the live time for the preload.
    always_comb begin
        h_tens = 2'd0;
        if (normal_hours >= 5'd20)      h_tens = 2'd2;
        else if (normal_hours >= 5'd10) h_tens = 2'd1;
        m_tens = 3'd0;
        if (normal_minutes >= 6'd50)      m_tens = 3'd5;
        else if (normal_minutes >= 6'd40) m_tens = 3'd4;
        else if (normal_minutes >= 6'd30) m_tens = 3'd3;
        else if (normal_minutes >= 6'd20) m_tens = 3'd2;
        else if (normal_minutes >= 6'd10) m_tens = 3'd1;
        h_ones = 4'(normal_hours - 5'(h_tens) * 5'd10);
        m_ones = 4'(normal_minutes - 6'(m_tens) * 6'd10);
    end

    // HL stepping 1->2 pulls an out-of-range HR down to 3 in the same edge.
    assign clamp_hr    = inc_hl && (set_time_hours_left == HL_MAX - 2'd1) &&
                         (set_time_hours_right > HR_MAX_H2);
    assign hr_max      = (set_time_hours_left == HL_MAX) ? HR_MAX_H2 : HR_MAX;
    assign hr_load_val = load_all ? h_ones : HR_MAX_H2;

    bcd_digit_counter #(.W(2)) u_hl (
        .clk(clk), .rst(rst), .load(load_all), .load_val(h_tens),
        .inc(inc_hl), .max(HL_MAX), .value(set_time_hours_left));

    bcd_digit_counter #(.W(4)) u_hr (
        .clk(clk), .rst(rst), .load(load_all | clamp_hr), .load_val(hr_load_val),
        .inc(inc_hr), .max(hr_max), .value(set_time_hours_right));

    bcd_digit_counter #(.W(3)) u_ml (
        .clk(clk), .rst(rst), .load(load_all), .load_val(m_tens),
        .inc(inc_ml), .max(ML_MAX), .value(set_time_minutes_left));

    bcd_digit_counter #(.W(4)) u_mr (
        .clk(clk), .rst(rst), .load(load_all), .load_val(m_ones),
        .inc(inc_mr), .max(MR_MAX), .value(set_time_minutes_right));

`ifdef SET_TIME_TIMEOUT_EN
    localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    logic [TW-1:0] to_cnt;

    assign to_hit = in_edit && (to_cnt == '0) && !btn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (load_all || (in_edit && btn)) begin
            to_cnt <= TW'(IDLE_TIMEOUT - 1);
        end else if (in_edit && (to_cnt != '0)) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end
`else
    // No inactivity abort in this build; the compare is constant false.
    assign to_hit = (IDLE_TIMEOUT < 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (set_time_en) state_nxt = ST_EDIT_HL;
            ST_EDIT_HL, ST_EDIT_HR, ST_EDIT_ML, ST_EDIT_MR: begin
                if (!set_time_en || to_hit) begin
                    state_nxt = ST_IDLE;
                end else if (next_button) begin
                    case (state)
                        ST_EDIT_HL: state_nxt = ST_EDIT_HR;
                        ST_EDIT_HR: state_nxt = ST_EDIT_ML;
                        ST_EDIT_ML: state_nxt = ST_EDIT_MR;
                        default:    state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_DONE: if (!set_time_en) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_sel         <= DIGIT_HL;
            set_time_ack_flag <= 1'b0;
            set_time_active   <= 1'b0;
        end else begin
            digit_sel         <= sel_of_state(state_nxt);
            set_time_ack_flag <= (state_nxt == ST_DONE);
            set_time_active   <= (state_nxt == ST_DONE) && (state != ST_DONE);
        end
    end

    // Blink phase: down-counter reloaded on edit entry and on every button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt   <= '0;
            digit_blink <= 1'b0;
        end else if (!nxt_edit) begin
            blink_cnt   <= '0;
            digit_blink <= 1'b0;
        end else if (!in_edit) begin
            blink_cnt   <= BW'(BLINK_DIV - 1);
            digit_blink <= 1'b0;
        end else if (btn) begin
            blink_cnt   <= BW'(BLINK_DIV - 1);
            digit_blink <= 1'b1;
        end else if (blink_cnt == '0) begin
            blink_cnt   <= BW'(BLINK_DIV - 1);
            digit_blink <= ~digit_blink;
        end else begin
            blink_cnt   <= blink_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_set_time_ctrl.sv
// Bench for set_time_ctrl: abstract digit-entry model checked every cycle,
// plus literal expectations along a directed button sequence.
module tb_set_time_ctrl;

    localparam int BD = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       set_time_en = 1'b0;
    logic       inc_button = 1'b0;
    logic       next_button = 1'b0;
    logic [4:0] normal_hours = '0;
    logic [5:0] normal_minutes = '0;
    logic [1:0] hl;
    logic [3:0] hr;
    logic [2:0] ml;
    logic [3:0] mr;
    logic       ack, active, blink;
    logic [1:0] sel;

    set_time_ctrl #(.BLINK_DIV(BD), .IDLE_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .set_time_en(set_time_en),
        .inc_button(inc_button), .next_button(next_button),
        .normal_hours(normal_hours), .normal_minutes(normal_minutes),
        .set_time_hours_left(hl), .set_time_hours_right(hr),
        .set_time_minutes_left(ml), .set_time_minutes_right(mr),
        .set_time_ack_flag(ack), .set_time_active(active),
        .digit_sel(sel), .digit_blink(blink));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Model: mode 0 idle, 1..4 editing digit mode-1, 5 done.
    int m_mode = 0;
    int m_d[4] = '{0, 0, 0, 0};
    int m_active = 0;
    int m_age = 0;
    int m_base = 0;
    int m_quiet = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int digit_limit(input int k);
        case (k)
            0:       return 2;
            1:       return (m_d[0] == 2) ? 3 : 9;
            2:       return 5;
            default: return 9;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_d = '{0, 0, 0, 0}; m_active = 0;
        m_age = 0; m_base = 0; m_quiet = 0;
    endtask

    task automatic model_step();
        int k;
        m_active = 0;
        if (m_mode == 0) begin
            if (set_time_en) begin
                m_mode = 1;
                m_d[0] = normal_hours / 10;  m_d[1] = normal_hours % 10;
                m_d[2] = normal_minutes / 10; m_d[3] = normal_minutes % 10;
                m_age = 0; m_base = 0; m_quiet = 0;
            end
        end else if (m_mode == 5) begin
            if (!set_time_en) m_mode = 0;
        end else if (!set_time_en) begin
            m_mode = 0;
        end else if (next_button || inc_button) begin
            if (next_button) begin
                m_mode = m_mode + 1;
                if (m_mode == 5) m_active = 1;
            end else begin
                k = m_mode - 1;
                m_d[k] = (m_d[k] >= digit_limit(k)) ? 0 : m_d[k] + 1;
                if (k == 0 && m_d[0] == 2 && m_d[1] > 3) m_d[1] = 3;
            end
            m_age = 0; m_base = 1; m_quiet = 0;
        end else begin
            m_age++;
`ifdef SET_TIME_TIMEOUT_EN
            if (m_quiet == TO - 1) m_mode = 0;
            else m_quiet++;
`endif
        end
    endtask

    function automatic int exp_sel();
        return (m_mode >= 1 && m_mode <= 4) ? m_mode - 1 : 0;
    endfunction

    function automatic int exp_blink();
        if (m_mode < 1 || m_mode > 4) return 0;
        return m_base ^ ((m_age / BD) % 2);
    endfunction

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("hl", 8'(hl), 8'(m_d[0]));
            check("hr", 8'(hr), 8'(m_d[1]));
            check("ml", 8'(ml), 8'(m_d[2]));
            check("mr", 8'(mr), 8'(m_d[3]));
            check("digit_sel", 8'(sel), 8'(exp_sel()));
            check("ack", 8'(ack), 8'(m_mode == 5));
            check("active", 8'(active), 8'(m_active));
            check("blink", 8'(blink), 8'(exp_blink()));
        end
    end

    task automatic cycle(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst) model_step();
            #1;
        end
    endtask

    task automatic press(input bit do_inc, input bit do_next);
        inc_button = do_inc; next_button = do_next;
        cycle();
        inc_button = 1'b0; next_button = 1'b0;
    endtask

    task automatic enter(input int h, input int m);
        normal_hours = 5'(h); normal_minutes = 6'(m); set_time_en = 1'b1;
        cycle();
    endtask

    initial begin
        model_reset();
        chk_en = 1'b1;
        #2;
        check("rst_digits", {hl, hr, 2'b0}, 8'd0);
        check("rst_flags", {4'd0, ack, active, blink, 1'b0}, 8'd0);
        cycle(2);
        rst = 1'b1;
        cycle(3);

        enter(17, 42);
        check("load_hl", 8'(hl), 8'd1);
        check("load_hr", 8'(hr), 8'd7);
        check("load_ml", 8'(ml), 8'd4);
        check("load_mr", 8'(mr), 8'd2);
        check("load_sel", 8'(sel), 8'd0);

        press(1, 0);
        check("clamp_hl", 8'(hl), 8'd2);
        check("clamp_hr", 8'(hr), 8'd3);
        press(0, 1);
        press(1, 0);
        check("hr_wrap_h2", 8'(hr), 8'd0);
        press(1, 1);
        check("both_hr", 8'(hr), 8'd0);
        check("both_sel", 8'(sel), 8'd2);

        for (int i = 0; i < 6; i++) press(1, 0);
        check("ml_cycle", 8'(ml), 8'd4);
        cycle(5);
        check("blink_off", 8'(blink), 8'd0);
        cycle(5);
        check("blink_on", 8'(blink), 8'd1);

        press(0, 1);
        for (int i = 0; i < 10; i++) press(1, 0);
        check("mr_cycle", 8'(mr), 8'd2);

        press(0, 1);
        check("done_active", 8'(active), 8'd1);
        check("done_ack", 8'(ack), 8'd1);
        cycle();
        check("active_once", 8'(active), 8'd0);
        press(1, 0);
        press(0, 1);
        cycle(2);
        check("ack_held", 8'(ack), 8'd1);
        set_time_en = 1'b0;
        cycle();
        check("ack_drop", 8'(ack), 8'd0);
        cycle(2);

        enter(23, 59);
        press(0, 1);
        press(0, 1);
        set_time_en = 1'b0;
        cycle();
        check("abort_ack", 8'(ack), 8'd0);
        check("abort_hold_ml", 8'(ml), 8'd5);
        cycle(2);

        enter(9, 0);
        press(1, 0);
        press(1, 0);
        check("hl_to2_hr", 8'(hr), 8'd3);
        press(1, 0);
        check("hl_wrap", 8'(hl), 8'd0);
        press(0, 1);
        press(1, 0);
        check("hr_inc", 8'(hr), 8'd4);
        set_time_en = 1'b0;
        cycle(2);

        enter(12, 34);
        cycle(6);
        press(1, 0);
        cycle(12);
        set_time_en = 1'b0;
        cycle(2);

        enter(20, 15);
        press(1, 0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("arst_digits", {hl, hr, 2'b0}, 8'd0);
        check("arst_lo", {1'b0, ml, mr}, 8'd0);
        check("arst_flags", {2'd0, sel, ack, active, blink, 1'b0}, 8'd0);
        set_time_en = 1'b0;
        cycle(2);
        rst = 1'b1;
        cycle(3);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
